// File: rtl/neuro_skin_pkg.sv
// neuro_skin_pkg
//   Shared constants and types for the skin-detection neuron: coefficient
//   register addresses, score/weight/bias widths, the product shift amount
//   and the threshold reset value.
package neuro_skin_pkg;

    localparam logic [2:0] ADDR_W0   = 3'd0;
    localparam logic [2:0] ADDR_W1   = 3'd1;
    localparam logic [2:0] ADDR_W2   = 3'd2;
    localparam logic [2:0] ADDR_W3   = 3'd3;
    localparam logic [2:0] ADDR_BIAS = 3'd4;
    localparam logic [2:0] ADDR_THR  = 3'd5;

    localparam int SCORE_W  = 18;
    localparam int WEIGHT_W = 16;
    localparam int BIAS_W   = 16;
    localparam int SHIFT    = 8;

    localparam logic signed [SCORE_W-1:0] THR_RESET = 18'sd131071;

    typedef logic signed [WEIGHT_W-1:0] weight_t;
    typedef logic signed [BIAS_W-1:0]   bias_t;
    typedef logic signed [SCORE_W-1:0]  score_t;

endpackage

// File: rtl/neuro_skin_coef.sv
// neuro_skin_coef
//   Coefficient register file for the neuron: four signed weights selected
//   by the dominant-channel index, one bias and one threshold. Writes happen
//   regardless of the pipeline clock enable.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   wr_en      write strobe
//   wr_addr    0-3 weight, 4 bias, 5 threshold, 6-7 no effect
//   wr_data    signed coefficient (weights/bias use the low 16 bits)
//   rd_index   weight select
//   rd_weight  selected weight
//   bias       current bias
//   threshold  current skin threshold
module neuro_skin_coef
    import neuro_skin_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [2:0]                wr_addr,
    input  logic signed [SCORE_W-1:0] wr_data,
    input  logic [1:0]                rd_index,
    output weight_t                   rd_weight,
    output bias_t                     bias,
    output score_t                    threshold
);

    weight_t weight_q [4];
    weight_t weight_d [4];
    bias_t   bias_q, bias_d;
    score_t  thr_q, thr_d;

    always_comb begin
        weight_d = weight_q;
        bias_d   = bias_q;
        thr_d    = thr_q;
        if (wr_en) begin
            case (wr_addr)
                ADDR_W0, ADDR_W1, ADDR_W2, ADDR_W3:
                    weight_d[wr_addr[1:0]] = wr_data[WEIGHT_W-1:0];
                ADDR_BIAS: bias_d = wr_data[BIAS_W-1:0];
                ADDR_THR:  thr_d  = wr_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            weight_q <= '{default: '0};
            bias_q   <= '0;
            thr_q    <= THR_RESET;
        end else begin
            weight_q <= weight_d;
            bias_q   <= bias_d;
            thr_q    <= thr_d;
        end
    end

    assign rd_weight = weight_q[rd_index];
    assign bias      = bias_q;
    assign threshold = thr_q;

endmodule

// File: rtl/neuro_skin_neuron.sv
// neuro_skin_neuron
//   Single-input neuron classifying a pixel as skin. The channel difference
//   is multiplied by a per-channel weight, scaled down by 2^8 (floor), offset
//   by a bias, saturated to 18 bits and compared against a threshold.
//   Three pipeline stages (select / multiply / bias+saturate+compare) that
//   advance only while ce is high. A saturating counter tallies skin hits.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   ce           pipeline clock enable
//   in_valid     qualifies value/index
//   value        unsigned channel difference
//   index        dominant-channel code, selects the weight
//   wr_en/wr_addr/wr_data  coefficient write port
//   clr_count    clears skin_count (wins over an increment)
//   out_valid    qualifies score/skin
//   score        saturated signed neuron output
//   skin         score >= threshold
//   skin_count   saturating count of skin results
module neuro_skin_neuron
    import neuro_skin_pkg::*;
#(
    parameter int DW = 10,
    parameter int CW = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      in_valid,
    input  logic [DW-1:0]             value,
    input  logic [1:0]                index,
    input  logic                      wr_en,
    input  logic [2:0]                wr_addr,
    input  logic signed [SCORE_W-1:0] wr_data,
    input  logic                      clr_count,
    output logic                      out_valid,
    output logic signed [SCORE_W-1:0] score,
    output logic                      skin,
    output logic [CW-1:0]             skin_count
);

    localparam int PROD_W = DW + 1 + WEIGHT_W;
    localparam int SH_W   = PROD_W - SHIFT;
    localparam int SUM_W  = SH_W + 1;

    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'((1 << (SCORE_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SUM_MIN = ~SUM_MAX;

    function automatic score_t sat_score(input logic signed [SUM_W-1:0] s);
        if (s > SUM_MAX)      return SUM_MAX[SCORE_W-1:0];
        else if (s < SUM_MIN) return SUM_MIN[SCORE_W-1:0];
        else                  return s[SCORE_W-1:0];
    endfunction

    weight_t rd_weight;
    bias_t   bias;
    score_t  threshold;

    neuro_skin_coef u_coef (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_index  (index),
        .rd_weight (rd_weight),
        .bias      (bias),
        .threshold (threshold)
    );

    logic [DW-1:0]           value_p1_q, value_p1_d;
    weight_t                 weight_p1_q, weight_p1_d;
    logic                    vld_p1_q, vld_p1_d;
    logic signed [PROD_W-1:0] product_p2;
    logic signed [SH_W-1:0]  shifted_p2_q, shifted_p2_d;
    logic                    vld_p2_q, vld_p2_d;
    logic signed [SUM_W-1:0] sum_p3;
    score_t                  score_next_p3;
    logic                    skin_next_p3;
    score_t                  score_q, score_d;
    logic                    skin_q, skin_d;
    logic                    vld_p3_q, vld_p3_d;
    logic [CW-1:0]           count_q, count_d;

    always_comb begin
        // ---- S1: capture sample and its weight
        value_p1_d  = ce ? value    : value_p1_q;
        weight_p1_d = ce ? rd_weight : weight_p1_q;
        vld_p1_d    = ce ? in_valid  : vld_p1_q;

        // ---- S2: widen, multiply, floor-shift by dropping low bits
        product_p2   = PROD_W'(signed'({1'b0, value_p1_q})) * PROD_W'(weight_p1_q);
        shifted_p2_d = ce ? product_p2[PROD_W-1:SHIFT] : shifted_p2_q;
        vld_p2_d     = ce ? vld_p1_q : vld_p2_q;

        // ---- S3: bias, saturate, compare; score/skin only move on a valid result
        sum_p3        = SUM_W'(shifted_p2_q) + SUM_W'(bias);
        score_next_p3 = sat_score(sum_p3);
        skin_next_p3  = (score_next_p3 >= threshold);
        vld_p3_d      = ce ? vld_p2_q : vld_p3_q;
        score_d       = score_q;
        skin_d        = skin_q;
        if (ce && vld_p2_q) begin
            score_d = score_next_p3;
            skin_d  = skin_next_p3;
        end

        // Count lands together with the result it counts.
        count_d = count_q;
        if (clr_count)
            count_d = '0;
        else if (ce && vld_p2_q && skin_next_p3 && (count_q != '1))
            count_d = count_q + CW'(1);
    end

    // Datapath registers carry no reset; validity is tracked by the vld chain.
    always_ff @(posedge clk) begin
        value_p1_q   <= value_p1_d;
        weight_p1_q  <= weight_p1_d;
        shifted_p2_q <= shifted_p2_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            score_q  <= '0;
            skin_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            score_q  <= score_d;
            skin_q   <= skin_d;
            count_q  <= count_d;
        end
    end

    assign out_valid  = vld_p3_q;
    assign score      = score_q;
    assign skin       = skin_q;
    assign skin_count = count_q;

endmodule

// File: doc/neuro_skin_neuron.md
NEURO_SKIN_NEURON -- requirements
Module: neuro_skin_neuron

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk (single clock, all logic on rising edge) and rst (synchronous, active-high).
REQ-002 SHALL have parameter DW, default 10, meaning the width of the input channel value.
REQ-003 SHALL have parameter CW, default 16, meaning the width of the skin counter.
REQ-004 SHALL have these ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ce  in  1  pipeline clock enable
- in_valid  in  1  value/index qualify
- value  in  DW  channel difference from the upstream RGB subtract stage, unsigned
- index  in  2  dominant-channel code from the upstream RGB subtract stage
- wr_en  in  1  coefficient write strobe
- wr_addr  in  3  0-3 = weight[index], 4 = bias, 5 = threshold, 6-7 = ignored
- wr_data  in  18  signed coefficient
- clr_count  in  1  clear skin_count
- out_valid  out  1  result qualify
- score  out  18  signed neuron output
- skin  out  1  score >= threshold
- skin_count  out  CW  saturating count of skin results

Function
REQ-005 SHALL implement a 3-stage pipeline (S1 select, S2 multiply, S3 bias/saturate/compare) advancing only when ce=1.
REQ-006 SHALL give latency of exactly 3 ce=1 cycles from in_valid sample to out_valid; with ce=0 all pipeline registers, including the valid chain, hold.
REQ-007 SHALL ignore in_valid and value/index when ce=0.
REQ-008 SHALL in S1 register value and weight[index], where weight = wr_data[15:0] signed.
REQ-009 SHALL in S2 compute product = signed({0,value}) * weight as 27-bit signed, then an arithmetic right shift by 8 (floor toward -inf), giving a 19-bit result.
REQ-010 SHALL in S3 compute sum = shifted + sign-extended bias(16b), 20-bit, then saturate to the 18-bit signed range [-131072, 131071] to form score.
REQ-011 SHALL set skin = (score >= threshold) as a signed 18-bit comparison, registered with score.
REQ-012 SHALL read weights at S1, and bias and threshold live at S3.
REQ-013 SHALL perform coefficient writes independent of ce, with the new value visible from the next clk edge.
REQ-014 SHALL increment skin_count on a cycle with ce=1, S3 valid and skin=1.
REQ-015 SHALL saturate skin_count at all-ones (no wrap).
REQ-016 SHALL make clr_count take priority over an increment in the same cycle, with a result of 0.
REQ-017 SHALL hold score and skin at their last value when out_valid=0; consumers use them only when out_valid=1.
REQ-018 SHALL leave all registers unchanged on writes to wr_addr 6-7.

Reset
REQ-019 SHALL on rst force out_valid=0, score=0, skin=0, skin_count=0, the valid chain cleared, weights 0-3 = 0, bias = 0 and threshold = 131071.
REQ-020 SHALL give rst priority over ce, wr_en and clr_count.
REQ-021 SHALL flush in-flight samples on rst mid-stream, producing no out_valid for them.

Structure
REQ-022 SHALL keep in the shared neuro_skin package: register address constants (ADDR_W0..ADDR_W3, ADDR_BIAS, ADDR_THR), SCORE_W=18, SHIFT=8, THR_RESET=131071.
REQ-023 SHALL place the coefficient register file (write port, 4-entry weight read mux, bias/threshold outputs) in sub-module neuro_skin_coef; the pipeline stays in the top.

Verification
REQ-024 SHALL cover basic: weight1=256, thr=50, value=100 idx=1 valid, ce=1 -> 3 cycles later out_valid=1, score=100, skin=1, skin_count=1.
REQ-025 SHALL cover saturation: weight2=32767, bias=16000, value=1023 idx=2 -> score=131071; weight2=-32768, bias=-16000 -> score=-131072.
REQ-026 SHALL cover floor shift: weight0=-1, bias=0, value=1 idx=0 -> score=-1; thr=0 -> skin=0.
REQ-027 SHALL cover stall: valid on cycle 0, ce low cycles 1-4, ce high otherwise -> out_valid exactly at cycle 7, single pulse; in_valid with ce=0 produces nothing.
REQ-028 SHALL cover counter: CW=4, 20 skin results -> skin_count=15; clr_count concurrent with skin result -> 0.
REQ-029 SHALL cover reset: rst with 3 valids in flight -> no out_valid afterward, threshold read back behaviour = 131071 (value=1023, weight=256 gives skin=0).
